// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
// Produces a registered divided clock (clk_out) plus a one-cycle tick at each
// rising edge of clk_out. Ratio changes are queued and applied only at a
// period boundary (or immediately when idle), so clk_out never has a runt pulse.
// Optional feature: define CLK_DIV_ODD_DUTY50_EN for an exact 50% duty on odd
// ratios (adds a negedge register that stretches the high phase by half a clk).
module clk_div_prog #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_active,
    output logic             load_err
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend;
    logic             pend_valid;
    logic             clk_q;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] hi_lim;
    logic             last;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;

    // Decode period boundary, high-phase limit and load legality
    always_comb begin
        half = div_active >> 1;
`ifdef CLK_DIV_ODD_DUTY50_EN
        // Odd ratios keep the posedge high phase at floor(N/2); the negedge
        // stage below adds the missing half cycle.
        hi_lim = div_active[0] ? half : (div_active - half);
`else
        hi_lim = div_active - half;
`endif
        last     = (cnt == (div_active - DIV_W'(1)));
        wrap     = en & last;
        load_ok  = div_load & (div_in >= DIV_W'(2));
        load_bad = div_load & (div_in <  DIV_W'(2));
    end

    // Period counter and registered divided-clock / tick outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clk_q    <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= (!en || last) ? '0 : (cnt + DIV_W'(1));
            clk_q    <= en & (cnt < hi_lim);
            tick     <= en & (cnt == '0);
            load_err <= load_bad;
        end
    end

    // Pending-ratio latch and boundary-aligned switchover
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_active <= DIV_W'(DEFAULT_DIV);
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (load_ok) begin
                pend       <= div_in;
                pend_valid <= 1'b1;
            end
            // A load landing on the wrap cycle bypasses pend so it takes
            // effect at this boundary; when idle, a load arriving while an
            // older value is being applied stays queued for the next cycle.
            if (wrap && (load_ok || pend_valid)) begin
                div_active <= load_ok ? div_in : pend;
                pend_valid <= 1'b0;
            end else if (!en && pend_valid) begin
                div_active <= pend;
                pend_valid <= load_ok;
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic odd_q;
    logic clk_n;

    // Track whether the registered clk_q phase belongs to an odd ratio
    always_ff @(posedge clk or posedge rst) begin
        if (rst) odd_q <= 1'b0;
        else     odd_q <= div_active[0];
    end

    // Half-cycle delayed copy that extends the high phase on odd ratios
    always_ff @(negedge clk or posedge rst) begin
        if (rst) clk_n <= 1'b0;
        else     clk_n <= clk_q & odd_q;
    end

    assign clk_out = clk_q | clk_n;
`else
    assign clk_out = clk_q;
`endif

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider.
- Generates a divided clock enable/strobe pair (clk_out, tick) from the 100 MHz system clock.
- Divide ratio is reloadable on the fly, with glitch-free switchover at period boundaries.
- Sits between the system clock and slow peripherals (LED scan, UART baud, PWM base) that need a retunable rate.

Parameters:
- DIV_W, 16, width of the divide ratio and internal counter.
- DEFAULT_DIV, 10, ratio active after reset; must satisfy 2 ≤ DEFAULT_DIV < 2^DIV_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; low = divider idle.
- div_load  in  1  one-cycle request to load div_in.
- div_in  in  DIV_W  requested divide ratio N.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse coincident with each clk_out rising edge.
- div_active  out  DIV_W  ratio currently in effect.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset values: cnt=0, clk_out=0, tick=0, div_active=DEFAULT_DIV, pend_valid=0, load_err=0.
- Counter: while en=1, cnt counts 0..N-1 and wraps to 0, with N=div_active. While en=0, cnt is forced to 0.
- H = N>>1 (floor).
- Outputs are registered, so values in cycle t reflect cnt in cycle t-1:
  - clk_out = en & (cnt < N-H), giving high for ceil(N/2) cycles and low for floor(N/2) cycles.
  - tick = en & (cnt==0).
- Even N: exact 50% duty. Odd N: high one cycle longer than low (see optional feature).
- Enable rise: the first cycle with en=1 has cnt=0. tick and clk_out rise one cycle later, so latency is 1.
- Enable fall: cnt returns to 0. clk_out and tick go 0 on the next cycle. Any partial period is abandoned.
- Load rules:
  - div_load=1 with div_in ≥ 2: div_in is latched into pend, pend_valid=1.
  - div_load=1 with div_in < 2: request ignored, load_err=1 for one cycle, pend unchanged.
- Apply rules:
  - If en=1, pend is applied at the wrap (cycle where cnt==N-1): the next cycle has div_active=pend, cnt=0, pend_valid=0.
  - If en=0, pend is applied on the cycle after the load.
- Edge cases:
  - Load in the same cycle as cnt==N-1 applies at that wrap.
  - A second load before the boundary overwrites pend; last writer wins.
  - Load with en falling in the same cycle: value is latched, then applied the next cycle because the divider is idle.
  - Any load clears nothing already in flight. The current period always completes with the old N, so clk_out never has a runt pulse.
- Maximum N = 2^DIV_W − 1. cnt has DIV_W bits; compare arithmetic is unsigned, DIV_W bits.
- rst asserted mid-operation clears everything immediately, including pend, and div_active returns to DEFAULT_DIV.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- When defined, a negedge-clk register delays the falling edge of clk_out by half a clk period for odd N. This gives high = low = N/2 clk periods, an exact 50% duty.
  - Even N is unchanged. tick is unchanged.
  - The extra register is cleared by rst.
- When undefined: posedge logic only, with the odd-N duty as stated above.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=10 → first tick 1 cycle after en, ticks every 10 cycles, clk_out high 5 / low 5; div_active=10.
- Load div_in=7 mid-period with en=1 → old period finishes at 10 cycles, then period 7. Without macro: high 4 / low 3. With macro: high 3.5 / low 3.5 clk periods.
- Load div_in=1, then div_in=0 → load_err pulses each time; div_active stays 10; period unchanged.
- Load 4 then 6 within the same period → only 6 takes effect at the wrap; no period of 4 occurs.
- en dropped mid-period with N=10 → clk_out=0 and tick=0 the next cycle. Re-enable → full 10-cycle period starting with tick after 1 cycle.
- Assert rst while N=6 and a pending load of 20 exists → all outputs reset; after release, div_active=10 and pend discarded.
